// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// The state encoding is fixed at 3 bits so it can be probed from a debug bus.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // States in which the loader consumes a byte from the host link.
    function automatic logic accepts_byte(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// word_ready pulses, with word held stable, the cycle after the 4th byte.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        ready_q, ready_d;

    always_comb begin
        shift_d = shift_q;
        lane_d  = lane_q;
        word_d  = word_q;
        ready_d = 1'b0;
        if (clear) begin
            shift_d = '0;
            lane_d  = '0;
        end else if (valid) begin
            shift_d = {shift_q[15:0], byte_in};
            lane_d  = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
                word_d  = {shift_q, byte_in};
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign word       = word_q;
    assign word_ready = ready_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: stalls the CPU, streams LEN/data/CSUM from the host link into
// instruction memory and verifies an 8-bit additive checksum of the data bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MAX_WORDS  = 1024,
    parameter bit BOOT_STALL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [1:0]          lane_q, lane_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                stall_q, stall_d;
    logic                err_q, err_d;

    logic                byte_fire;
    logic                start_ok;
    logic [LEN_W-1:0]    len_full;
    logic                pk_ready;
    logic [31:0]         pk_word;

    assign rx_ready  = accepts_byte(state_q);
    assign byte_fire = rx_valid && rx_ready;
    assign start_ok  = start && (state_q == ST_IDLE);
    assign len_full  = {len_q[LEN_W-1:8], rx_data};

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .valid      (byte_fire && (state_q == ST_DATA)),
        .byte_in    (rx_data),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        lane_d     = lane_q;
        csum_d     = csum_q;
        waddr_d    = waddr_q;
        stall_d    = stall_q;
        err_d      = err_q;

        // Address advances after each write; a new session overrides it below.
        if (pk_ready) begin
            waddr_d = waddr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    stall_d    = 1'b1;
                    err_d      = 1'b0;
                    waddr_d    = '0;
                    csum_d     = '0;
                    len_d      = '0;
                    word_cnt_d = '0;
                    lane_d     = '0;
                end
            end
            ST_LEN_HI: begin
                if (byte_fire) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_fire) begin
                    len_d = len_full;
                    if (len_full > LEN_W'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_fire) begin
                    csum_d = csum_q + rx_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        if (word_cnt_q + LEN_W'(1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (byte_fire) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stall_d = 1'b0;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            csum_q     <= '0;
            waddr_q    <= '0;
            stall_q    <= BOOT_STALL;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            lane_q     <= lane_d;
            csum_q     <= csum_d;
            waddr_q    <= waddr_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign mem_we    = pk_ready;
    assign mem_waddr = waddr_q;
    assign mem_wdata = pk_word;
    assign cpu_stall = stall_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one task per scenario, inline comparisons,
// a passive monitor logging memory writes and done pulses.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_stall;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .MAX_WORDS  (1024),
        .BOOT_STALL (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_stall (cpu_stall),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_waddr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%0d data=%08h", mem_waddr, mem_wdata);
        end
        if (done) done_cnt++;
    end

    logic [7:0] stm [0:15];
    int         gap_pat [4] = '{0, 2, 1, 3};

    // Two-word program DEADBEEF, 00000001; data-byte sum DE+AD+BE+EF+01 = 0x339 -> 0x39.
    task automatic set_two_word(input logic [7:0] c);
        stm[0] = 8'h00; stm[1] = 8'h02;
        stm[2] = 8'hDE; stm[3] = 8'hAD; stm[4] = 8'hBE; stm[5] = 8'hEF;
        stm[6] = 8'h00; stm[7] = 8'h00; stm[8] = 8'h00; stm[9] = 8'h01;
        stm[10] = c;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Presents a byte after 'gap' idle cycles; returns at the negedge before it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        repeat (gap) begin
            @(negedge clk); rx_valid = 1'b0;
        end
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        tmo = 0;
        while (!rx_ready && tmo < 50) begin
            @(negedge clk); tmo++;
        end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
        end
        $display("byte %02h sent", b);
    endtask

    task automatic send_stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) send_byte(stm[i], gaps ? gap_pat[i % 4] : 0);
    endtask

    task automatic wait_end(output bit got_done, output bit got_err);
        int k;
        @(negedge clk); rx_valid = 1'b0;
        got_done = 1'b0; got_err = 1'b0;
        k = 0;
        while (!done && !err && k < 20) begin
            @(negedge clk); k++;
        end
        got_done = done;
        got_err  = err;
        if (!done && !err) begin
            checks++; errors++;
            $display("FAIL end_timeout: neither done nor err within 20 cycles");
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = {cpu_stall, rx_ready, mem_we, busy, done, err};
        checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: {stall,ready,we,busy,done,err}=%b required 100000", obs);
        end
        checks++;
        if (mem_waddr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: waddr=%0d wdata=%08h required 0/00000000", mem_waddr, mem_wdata);
        end
        $display("reset checked");
    endtask

    task automatic test_load_ok(input bit gaps);
        bit d, e;
        logic [83:0] obs;
        clear_log();
        set_two_word(8'h39);
        do_start();
        checks++;
        if (busy !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: busy=%b stall=%b required 1/1", busy, cpu_stall);
        end
        send_stream(11, gaps);
        wait_end(d, e);
        checks++;
        if (d !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL load_end: done=%b err=%b required 1/0", d, e);
        end
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_release: stall=%b busy=%b required 0/0", cpu_stall, busy);
        end
        repeat (2) @(negedge clk);
        obs = '1;
        if (wr_addr_q.size() == 2) obs = {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]};
        checks++;
        if (wr_addr_q.size() != 2 || obs !== {10'd0, 32'hDEADBEEF, 10'd1, 32'h00000001}) begin
            errors++;
            $display("FAIL load_writes: count=%0d data=%h required 2 writes 0:DEADBEEF 1:00000001",
                     wr_addr_q.size(), obs);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL load_done_pulses: %0d required 1", done_cnt);
        end
        $display("load (gaps=%0b) checked", gaps);
    endtask

    task automatic test_bad_csum();
        bit d, e;
        logic [83:0] obs;
        clear_log();
        set_two_word(8'h20);
        do_start();
        send_stream(11, 1'b0);
        wait_end(d, e);
        checks++;
        if (e !== 1'b1 || d !== 1'b0) begin
            errors++;
            $display("FAIL csum_end: err=%b done=%b required 1/0", e, d);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || cpu_stall !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_sticky: err=%b stall=%b busy=%b required 1/1/0", err, cpu_stall, busy);
        end
        obs = '1;
        if (wr_addr_q.size() == 2) obs = {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]};
        checks++;
        if (wr_addr_q.size() != 2 || obs !== {10'd0, 32'hDEADBEEF, 10'd1, 32'h00000001} || done_cnt != 0) begin
            errors++;
            $display("FAIL csum_writes: count=%0d data=%h done_cnt=%0d required 2 writes, 0 done",
                     wr_addr_q.size(), obs, done_cnt);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL csum_restart: err=%b busy=%b required 0/1", err, busy);
        end
        // Finish the restarted session with an empty program.
        stm[0] = 8'h00; stm[1] = 8'h00; stm[2] = 8'h00;
        send_stream(3, 1'b0);
        wait_end(d, e);
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL csum_recover: done=%b required 1", d);
        end
        repeat (2) @(negedge clk);
        $display("bad checksum checked");
    endtask

    task automatic test_len_overflow();
        bit d, e;
        clear_log();
        do_start();
        stm[0] = 8'h04; stm[1] = 8'h01;
        send_stream(2, 1'b0);
        wait_end(d, e);
        checks++;
        if (e !== 1'b1 || d !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end: err=%b done=%b required 1/0", e, d);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || err !== 1'b1 || cpu_stall !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_state: writes=%0d err=%b stall=%b busy=%b required 0/1/1/0",
                     wr_addr_q.size(), err, cpu_stall, busy);
        end
        $display("length overflow checked");
    endtask

    task automatic test_len_zero();
        bit d, e;
        clear_log();
        do_start();
        stm[0] = 8'h00; stm[1] = 8'h00; stm[2] = 8'h00;
        send_stream(3, 1'b0);
        wait_end(d, e);
        checks++;
        if (d !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_end: done=%b err=%b required 1/0", d, e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || done_cnt != 1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_state: writes=%0d done_cnt=%0d stall=%b required 0/1/0",
                     wr_addr_q.size(), done_cnt, cpu_stall);
        end
        $display("zero length checked");
    endtask

    task automatic test_reset_abort();
        clear_log();
        set_two_word(8'h39);
        do_start();
        send_stream(4, 1'b0);
        @(negedge clk); rx_valid = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0 || rx_ready !== 1'b0 ||
            cpu_stall !== 1'b1 || mem_waddr !== '0) begin
            errors++;
            $display("FAIL abort_state: writes=%0d busy=%b ready=%b stall=%b waddr=%0d required 0/0/0/1/0",
                     wr_addr_q.size(), busy, rx_ready, cpu_stall, mem_waddr);
        end
        $display("reset abort checked");
        test_load_ok(1'b0);
    endtask

    initial begin
        test_reset();
        test_load_ok(1'b0);
        test_bad_csum();
        test_len_overflow();
        test_len_zero();
        test_load_ok(1'b1);
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
